// File: rtl/cmp_match_tracker.sv
// Tracks runs of RUN_LEN consecutive comparator matches and presents each completed run
// as a held valid/ready event, with saturating match and event statistics.
module cmp_match_tracker #(
  parameter int unsigned RUN_LEN = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             z_in,
  output logic             in_ready,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       run_len,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int unsigned RL_W = 8;
  localparam logic [RL_W-1:0] RUN_TGT = RL_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [RL_W-1:0]  run_len_nxt;
  logic [CNT_W-1:0] match_cnt_nxt, evt_cnt_nxt;
  logic             accept;

  // State and registered outputs; in_ready/evt_valid are decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run_len   <= '0;
      match_cnt <= '0;
      evt_cnt   <= '0;
      evt_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nxt;
      run_len   <= run_len_nxt;
      match_cnt <= match_cnt_nxt;
      evt_cnt   <= evt_cnt_nxt;
      evt_valid <= (state_nxt == HOLD);
      in_ready  <= (state_nxt != HOLD);
    end
  end

  // Next-state, run length and saturating statistics.
  always_comb begin
    state_nxt     = state;
    run_len_nxt   = run_len;
    match_cnt_nxt = match_cnt;
    evt_cnt_nxt   = evt_cnt;
    accept        = in_valid && in_ready;

    if (accept && z_in && (match_cnt != CNT_MAX)) begin
      match_cnt_nxt = match_cnt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        if (accept && z_in) begin
          run_len_nxt = RL_W'(1);
          state_nxt   = (RUN_TGT == RL_W'(1)) ? HOLD : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (z_in) begin
            run_len_nxt = run_len + RL_W'(1);
            if (run_len_nxt == RUN_TGT) begin
              state_nxt = HOLD;
            end
          end else begin
            run_len_nxt = '0;
            state_nxt   = IDLE;
          end
        end
      end
      HOLD: begin
        if (evt_ready) begin
          run_len_nxt = '0;
          state_nxt   = IDLE;
          if (evt_cnt != CNT_MAX) begin
            evt_cnt_nxt = evt_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        run_len_nxt = '0;
        state_nxt   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cmp_match_tracker.sv
// Self-checking bench: three tracker configurations share one stimulus stream and are
// compared against an abstract run/pending/count model.
module tb_cmp_match_tracker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic z_in = 1'b0;
  logic evt_ready = 1'b0;

  logic       rdy [3];
  logic       ev  [3];
  logic [7:0] rl  [3];
  logic [7:0] mc  [3];
  logic [7:0] ec  [3];
  logic [7:0] mc_a, ec_a, mc_c, ec_c;
  logic [1:0] mc_b, ec_b;

  int errors = 0;
  int checks = 0;

  // Reference model: a run counter, a pending-event flag and clamped counts.
  int unsigned p_len [3] = '{3, 3, 1};
  int unsigned p_max [3] = '{255, 3, 255};
  int unsigned m_run [3];
  int unsigned m_match [3];
  int unsigned m_evt [3];
  bit          m_pend [3];

  always #5 clk = ~clk;

  cmp_match_tracker #(.RUN_LEN(3), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .z_in(z_in), .in_ready(rdy[0]),
    .evt_valid(ev[0]), .evt_ready(evt_ready), .run_len(rl[0]), .match_cnt(mc_a),
    .evt_cnt(ec_a));

  cmp_match_tracker #(.RUN_LEN(3), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .z_in(z_in), .in_ready(rdy[1]),
    .evt_valid(ev[1]), .evt_ready(evt_ready), .run_len(rl[1]), .match_cnt(mc_b),
    .evt_cnt(ec_b));

  cmp_match_tracker #(.RUN_LEN(1), .CNT_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .z_in(z_in), .in_ready(rdy[2]),
    .evt_valid(ev[2]), .evt_ready(evt_ready), .run_len(rl[2]), .match_cnt(mc_c),
    .evt_cnt(ec_c));

  assign mc[0] = mc_a;
  assign ec[0] = ec_a;
  assign mc[1] = 8'(mc_b);
  assign ec[1] = 8'(ec_b);
  assign mc[2] = mc_c;
  assign ec[2] = ec_c;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0; m_match[i] = 0; m_evt[i] = 0; m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit v, input bit z, input bit r);
    for (int i = 0; i < 3; i++) begin
      if (m_pend[i]) begin
        if (r) begin
          m_pend[i] = 1'b0;
          m_run[i]  = 0;
          m_evt[i]  = (m_evt[i] + 1 > p_max[i]) ? p_max[i] : m_evt[i] + 1;
        end
      end else if (v) begin
        if (z) begin
          m_match[i] = (m_match[i] + 1 > p_max[i]) ? p_max[i] : m_match[i] + 1;
          m_run[i]   = m_run[i] + 1;
          if (m_run[i] == p_len[i]) m_pend[i] = 1'b1;
        end else begin
          m_run[i] = 0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle 1 time unit past the edge.
  task automatic clk_step(input bit v, input bit z, input bit r);
    in_valid = v; z_in = z; evt_ready = r;
    @(posedge clk);
    model_step(v, z, r);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) clk_step(1'b1, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rl[i] !== 8'd0 || mc[i] !== 8'd0 || ec[i] !== 8'd0 || ev[i] !== 1'b0 || rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset[%0d]: got rl=%0d mc=%0d ec=%0d ev=%b rdy=%b want 0 0 0 0 1",
                 i, rl[i], mc[i], ec[i], ev[i], rdy[i]);
      end
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] exp_rl [3] = '{8'd1, 8'd2, 8'd3};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      clk_step(1'b1, 1'b1, 1'b0);
      checks++;
      if (rl[0] !== exp_rl[k]) begin
        errors++;
        $display("FAIL basic_run_len step %0d: got %0d want %0d", k, rl[0], exp_rl[k]);
      end
    end
    checks++;
    if (ev[0] !== 1'b1 || rdy[0] !== 1'b0 || mc[0] !== 8'd3) begin
      errors++;
      $display("FAIL basic_event: got ev=%b rdy=%b mc=%0d want 1 0 3", ev[0], rdy[0], mc[0]);
    end
  endtask

  task automatic test_broken();
    bit         zs     [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp_rl [4] = '{8'd1, 8'd2, 8'd0, 8'd1};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      clk_step(1'b1, zs[k], 1'b0);
      checks++;
      if (rl[0] !== exp_rl[k] || ev[0] !== 1'b0) begin
        errors++;
        $display("FAIL broken step %0d: got rl=%0d ev=%b want %0d 0", k, rl[0], ev[0], exp_rl[k]);
      end
    end
    checks++;
    if (mc[0] !== 8'd3) begin
      errors++;
      $display("FAIL broken_match_cnt: got %0d want 3", mc[0]);
    end
  endtask

  task automatic test_back_pressure();
    apply_reset();
    for (int k = 0; k < 3; k++) clk_step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      clk_step(1'b1, 1'b1, 1'b0);
      checks++;
      if (ev[0] !== 1'b1 || mc[0] !== 8'd3 || rdy[0] !== 1'b0) begin
        errors++;
        $display("FAIL backpressure hold %0d: got ev=%b mc=%0d rdy=%b want 1 3 0", k, ev[0], mc[0], rdy[0]);
      end
    end
    clk_step(1'b0, 1'b0, 1'b1);
    checks++;
    if (ev[0] !== 1'b0 || ec[0] !== 8'd1 || rl[0] !== 8'd0 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_take: got ev=%b ec=%0d rl=%0d rdy=%b want 0 1 0 1",
               ev[0], ec[0], rl[0], rdy[0]);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    // Four events need 16 cycles with everything asserted; 12 z=1 samples get accepted.
    for (int k = 0; k < 16; k++) begin
      clk_step(1'b1, 1'b1, 1'b1);
      checks++;
      if (mc[1] !== 8'(m_match[1]) || ec[1] !== 8'(m_evt[1])) begin
        errors++;
        $display("FAIL sat cycle %0d: got mc=%0d ec=%0d want %0d %0d", k, mc[1], ec[1], m_match[1], m_evt[1]);
      end
    end
    checks++;
    if (mc[1] !== 8'd3 || ec[1] !== 8'd3) begin
      errors++;
      $display("FAIL sat_final: got mc=%0d ec=%0d want 3 3", mc[1], ec[1]);
    end
  endtask

  task automatic test_abort();
    apply_reset();
    for (int k = 0; k < 3; k++) clk_step(1'b1, 1'b1, 1'b0);
    checks++;
    if (ev[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: got ev=%b want 1", ev[0]);
    end
    apply_reset();
    clk_step(1'b0, 1'b0, 1'b1);
    checks++;
    if (ev[0] !== 1'b0 || ec[0] !== 8'd0 || rl[0] !== 8'd0) begin
      errors++;
      $display("FAIL abort: got ev=%b ec=%0d rl=%0d want 0 0 0", ev[0], ec[0], rl[0]);
    end
  endtask

  task automatic test_run_len_one();
    bit v [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit z [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit r [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit e [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      clk_step(v[k], z[k], r[k]);
      checks++;
      if (ev[2] !== e[k] || rdy[2] !== !e[k]) begin
        errors++;
        $display("FAIL runlen1 step %0d: got ev=%b rdy=%b want %b %b", k, ev[2], rdy[2], e[k], !e[k]);
      end
    end
    checks++;
    if (ec[2] !== 8'd2 || mc[2] !== 8'd2) begin
      errors++;
      $display("FAIL runlen1_counts: got ec=%0d mc=%0d want 2 2", ec[2], mc[2]);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      clk_step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) == 0));
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rl[i] !== 8'(m_run[i]) || mc[i] !== 8'(m_match[i]) || ec[i] !== 8'(m_evt[i]) ||
            ev[i] !== m_pend[i] || rdy[i] !== !m_pend[i]) begin
          errors++;
          $display("FAIL random[%0d] cycle %0d: got rl=%0d mc=%0d ec=%0d ev=%b rdy=%b want %0d %0d %0d %b %b",
                   i, k, rl[i], mc[i], ec[i], ev[i], rdy[i],
                   m_run[i], m_match[i], m_evt[i], m_pend[i], !m_pend[i]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    #12;
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_broken();
    test_back_pressure();
    test_saturation();
    test_abort();
    test_run_len_one();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
